// File: rtl/req_gnt_monitor_if.sv
// Request/grant monitor bus: handshake inputs seen by the monitor plus its status outputs.
// The master side drives the handshake and clear, and the slave side is the monitor itself.
interface req_gnt_monitor_if #(
    parameter int CNT_W = 8
);
    logic             req;
    logic             qual;
    logic             gnt;
    logic             clr;
    logic             busy;
    logic             lat_valid;
    logic [3:0]       lat_out;
    logic             err_pulse;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             spur_sticky;

    modport master (
        output req, qual, gnt, clr,
        input  busy, lat_valid, lat_out, err_pulse, err_sticky, err_cnt, spur_sticky
    );

    modport slave (
        input  req, qual, gnt, clr,
        output busy, lat_valid, lat_out, err_pulse, err_sticky, err_cnt, spur_sticky
    );
endinterface

// File: rtl/req_gnt_monitor.sv
// Request-to-grant latency monitor.
// A qualified request starts a latency timer. A grant within MAX_LAT cycles reports the
// measured latency. Otherwise a timeout is flagged and counted. A grant arriving with no
// request outstanding is latched as spurious. Every output is registered.
module req_gnt_monitor #(
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    req_gnt_monitor_if.slave       bus
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t           state_q;
    logic [3:0]       timer_q;
    logic             busy_q;
    logic             latValid_q;
    logic [3:0]       latOut_q;
    logic             errPulse_q;
    logic             errSticky_q;
    logic [CNT_W-1:0] errCnt_q;
    logic [CNT_W-1:0] errCnt_d;
    logic             spurSticky_q;
    logic             accept;

    assign accept = bus.req && bus.qual;

    // Saturating increment of the timeout counter, so that it holds at all-ones instead of wrapping.
    always_comb begin
        errCnt_d = errCnt_q;
        if (errCnt_q != {CNT_W{1'b1}}) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end
    end

    // Monitor FSM with registered outputs. The clear is applied last so that it overrides any sticky or counter update made at the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= 4'd0;
            busy_q       <= 1'b0;
            latValid_q   <= 1'b0;
            latOut_q     <= 4'd0;
            errPulse_q   <= 1'b0;
            errSticky_q  <= 1'b0;
            errCnt_q     <= '0;
            spurSticky_q <= 1'b0;
        end else begin
            latValid_q <= 1'b0;
            errPulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.gnt) begin
                        spurSticky_q <= 1'b1;
                    end
                    if (accept) begin
                        state_q <= ST_WAIT;
                        timer_q <= 4'd1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.gnt) begin
                        latValid_q <= 1'b1;
                        latOut_q   <= timer_q;
                        if (accept) begin
                            timer_q <= 4'd1;
                        end else begin
                            state_q <= ST_IDLE;
                            timer_q <= 4'd0;
                            busy_q  <= 1'b0;
                        end
                    end else if (timer_q == 4'(MAX_LAT)) begin
                        errPulse_q  <= 1'b1;
                        errSticky_q <= 1'b1;
                        errCnt_q    <= errCnt_d;
                        state_q     <= ST_IDLE;
                        timer_q     <= 4'd0;
                        busy_q      <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
            if (bus.clr) begin
                errSticky_q  <= 1'b0;
                spurSticky_q <= 1'b0;
                errCnt_q     <= '0;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.lat_valid   = latValid_q;
    assign bus.lat_out     = latOut_q;
    assign bus.err_pulse   = errPulse_q;
    assign bus.err_sticky  = errSticky_q;
    assign bus.err_cnt     = errCnt_q;
    assign bus.spur_sticky = spurSticky_q;

endmodule

// File: doc/req_gnt_monitor.md
REQ_GNT_MONITOR -- requirements
Module: req_gnt_monitor

Interface
REQ-001 Parameter MAX_LAT, default 3: maximum allowed request-to-grant latency in cycles; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  request strobe from the upstream stage.
REQ-006 qual  input  1  request qualifier; a request is accepted only when req and qual are both high.
REQ-007 gnt  input  1  grant from the downstream registered stage.
REQ-008 clr  input  1  clears err_sticky, spur_sticky and err_cnt.
REQ-009 busy  output  1  high while a request is outstanding (state WAIT).
REQ-010 lat_valid  output  1  one-cycle pulse: grant received in time.
REQ-011 lat_out  output  4  measured latency in cycles; valid only with lat_valid.
REQ-012 err_pulse  output  1  one-cycle pulse: grant timeout.
REQ-013 err_sticky  output  1  set on timeout; held until clr or reset.
REQ-014 err_cnt  output  CNT_W  count of timeouts, saturating.
REQ-015 spur_sticky  output  1  set when gnt is high in IDLE; held until clr or reset.

Function
REQ-016 All inputs are sampled on posedge clk; all outputs are registered.
REQ-017 FSM states: IDLE, WAIT; 4-bit timer register.
REQ-018 IDLE: req&&qual sampled high -> WAIT, timer=1, busy=1 from the next cycle.
REQ-019 IDLE: gnt sampled high -> spur_sticky=1; state remains IDLE; a simultaneous req&&qual is still accepted.
REQ-020 WAIT, gnt high: lat_valid=1 and lat_out=timer for one cycle; next state IDLE, or WAIT with timer=1 if req&&qual is high at the same edge.
REQ-021 WAIT, gnt low, timer==MAX_LAT: err_pulse=1 for one cycle; err_sticky=1; err_cnt+1; next state IDLE.
REQ-022 WAIT, gnt low, timer<MAX_LAT: timer+1; stay WAIT.
REQ-023 req&&qual while in WAIT (other than as in REQ-020): ignored; no queuing of a second request.
REQ-024 err_cnt saturates at all-ones; it never wraps to 0.
REQ-025 clr at the same edge as a timeout: err_pulse still asserts; err_sticky=0; err_cnt=0 (clr wins).
REQ-026 clr at the same edge as a spurious grant: spur_sticky=0 (clr wins).
REQ-027 clr does not affect state, timer, busy, lat_valid or lat_out.
REQ-028 lat_valid and err_pulse are never high in the same cycle.
REQ-029 Grant at timer==MAX_LAT counts as in time (REQ-020 has priority over REQ-021).

Reset
REQ-030 rst_n low at posedge: state=IDLE, timer=0, busy=0, lat_valid=0, lat_out=0, err_pulse=0, err_sticky=0, err_cnt=0, spur_sticky=0.
REQ-031 Reset mid-WAIT abandons the outstanding request with no pulse or count.
REQ-032 Inputs are ignored during reset; the first acceptance is possible at the first posedge with rst_n high.

Verification (MAX_LAT=3, CNT_W=8)
REQ-033 req=qual=1 for one cycle, gnt high one cycle later -> lat_valid pulse with lat_out=1; busy back to 0; err_cnt=0.
REQ-034 req=qual=1, gnt high exactly 3 cycles later -> lat_valid with lat_out=3; no err_pulse.
REQ-035 req=qual=1, gnt never asserted -> err_pulse 3 cycles after acceptance; err_sticky=1; err_cnt=1. Repeat 300 times -> err_cnt=255.
REQ-036 req=1, qual=0, then gnt=1 -> no acceptance; spur_sticky=1. Then clr=1 -> spur_sticky=0.
REQ-037 Request accepted, rst_n low for one cycle in WAIT -> all outputs 0; no err_pulse afterwards.
REQ-038 Timeout and clr at the same edge -> err_pulse=1, err_cnt=0, err_sticky=0. Grant and a new req&&qual at the same edge -> lat_valid, busy stays 1, new timer=1.
